// File: rtl/tach_pulse_emulator.sv
// Tachometer pulse transmitter: slew-limited motor speed model driving a
// single-channel phase-accumulator pulse train on the shared clk_en tick.
module tach_pulse_emulator #(
  parameter int TICK_HZ        = 10000,
  parameter int PULSES_PER_REV = 360,
  parameter int MAX_RPM        = 833,
  parameter int SLEW_RPM       = 10,
  parameter int SLEW_TICKS     = 100
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        clk_en,
  input  logic        enable_in,
  input  logic        target_load_in,
  input  logic [9:0]  target_rpm_in,
  output logic        tach_pulse_out,
  output logic [9:0]  current_rpm_out,
  output logic        at_target_out,
  output logic [15:0] pulse_count_out,
  output logic [1:0]  state_out
);

  localparam logic [1:0] STOPPED  = 2'd0;
  localparam logic [1:0] RAMPING  = 2'd1;
  localparam logic [1:0] AT_SPEED = 2'd2;

  localparam int          SLEW_W     = (SLEW_TICKS > 1) ? $clog2(SLEW_TICKS) : 1;
  localparam logic [19:0] HALF       = 20'(30 * TICK_HZ);
  localparam logic [9:0]  MAX_RPM_V  = 10'(MAX_RPM);
  localparam logic [9:0]  SLEW_RPM_V = 10'(SLEW_RPM);
  localparam logic [SLEW_W-1:0] SLEW_LAST = SLEW_W'(SLEW_TICKS - 1);

  logic [9:0]        target_rpm;
  logic [9:0]        current_rpm;
  logic [9:0]        eff_target;
  logic [9:0]        rpm_diff;
  logic [9:0]        next_rpm;
  logic [SLEW_W-1:0] slew_cnt;
  logic [19:0]       acc;
  logic [19:0]       phase_inc;
  logic [19:0]       phase_sum;
  logic              tach;
  logic [15:0]       pulse_count;
  logic [1:0]        state;

  assign eff_target = enable_in ? target_rpm : 10'd0;
  assign phase_inc  = 20'(current_rpm) * 20'(PULSES_PER_REV);
  assign phase_sum  = acc + phase_inc;

  always_comb begin
    next_rpm = current_rpm;
    rpm_diff = 10'd0;
    if (current_rpm < eff_target) begin
      rpm_diff = eff_target - current_rpm;
      next_rpm = (rpm_diff > SLEW_RPM_V) ? current_rpm + SLEW_RPM_V : eff_target;
    end else if (current_rpm > eff_target) begin
      rpm_diff = current_rpm - eff_target;
      next_rpm = (rpm_diff > SLEW_RPM_V) ? current_rpm - SLEW_RPM_V : eff_target;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      target_rpm <= '0;
    end else if (target_load_in) begin
      target_rpm <= (target_rpm_in > MAX_RPM_V) ? MAX_RPM_V : target_rpm_in;
    end
  end

  // A load coinciding with a step lands after it, so the step sees the old target.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      slew_cnt    <= '0;
      current_rpm <= '0;
    end else if (clk_en) begin
      if (slew_cnt == SLEW_LAST) begin
        slew_cnt    <= '0;
        current_rpm <= next_rpm;
      end else begin
        slew_cnt <= slew_cnt + 1'b1;
      end
    end
  end

  // Increment never reaches HALF, so at most one toggle per tick.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      acc         <= '0;
      tach        <= 1'b0;
      pulse_count <= '0;
    end else if (clk_en) begin
      if (current_rpm == 10'd0) begin
        acc  <= '0;
        tach <= 1'b0;
      end else if (phase_sum >= HALF) begin
        acc  <= phase_sum - HALF;
        tach <= ~tach;
        if (!tach) begin
          pulse_count <= pulse_count + 16'd1;
        end
      end else begin
        acc <= phase_sum;
      end
    end
  end

  always_comb begin
    if (current_rpm != eff_target) begin
      state = RAMPING;
    end else if (current_rpm == 10'd0) begin
      state = STOPPED;
    end else begin
      state = AT_SPEED;
    end
  end

  assign tach_pulse_out  = tach;
  assign current_rpm_out = current_rpm;
  assign at_target_out   = (current_rpm == eff_target);
  assign pulse_count_out = pulse_count;
  assign state_out       = state;

endmodule
